// File: rtl/core_pkg.sv
// Shared RV32I core definitions: opcode constants, controller states,
// opcode classes and the datapath control encodings.
package core_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_BRANCH,
        S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_ILLEGAL
    } opclass_t;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] SRC_A_PC     = 2'd0;
    localparam logic [1:0] SRC_A_RS1    = 2'd1;
    localparam logic [1:0] SRC_A_OLD_PC = 2'd2;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_IMM  = 2'd2;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       wb_sel;
        logic       instr_done;
        logic       trap;
    } ctrl_t;

    // All-inactive control word: the value of every output outside the
    // cycles that explicitly drive it, and the forced value during reset.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c = '0;
        return c;
    endfunction

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode classifier shared by the DECODE and MEM_ADDR steps.
module opcode_class
    import core_pkg::*;
(
    input  logic [6:0] i_opcode,
    output opclass_t   o_class
);

    always_comb begin
        o_class = CLS_ILLEGAL;
        case (i_opcode)
            OP_R:      o_class = CLS_R;
            OP_I:      o_class = CLS_I;
            OP_LOAD:   o_class = CLS_LOAD;
            OP_STORE:  o_class = CLS_STORE;
            OP_BRANCH: o_class = CLS_BRANCH;
            default:   o_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/
// write-back and drives datapath enables, mux selects and the memory handshake.
module multicycle_ctrl
    import core_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       wb_sel,
    output logic       instr_done,
    output logic       trap
);

    state_t   r_state;
    state_t   w_state_next;
    opclass_t w_class;
    ctrl_t    w_ctrl;

    // funct fields are consumed by the datapath ALU decoder and branch
    // comparator; the sequencer itself never looks at them.
    logic w_unused_funct;
    assign w_unused_funct = ^{funct3, funct7};

    opcode_class u_opcode_class (
        .i_opcode (opcode),
        .o_class  (w_class)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_ctrl       = ctrl_idle();
        w_state_next = r_state;

        case (r_state)
            S_FETCH: begin
                w_ctrl.mem_req   = 1'b1;
                w_ctrl.iord      = 1'b0;
                w_ctrl.alu_src_a = SRC_A_PC;
                w_ctrl.alu_src_b = SRC_B_FOUR;
                w_ctrl.alu_op    = ALU_ADD;
                if (mem_ready) begin
                    w_ctrl.ir_write = 1'b1;
                    w_ctrl.pc_write = 1'b1;
                    w_state_next    = S_DECODE;
                end
            end

            S_DECODE: begin
                // Branch target is precomputed here from the old PC.
                w_ctrl.alu_src_a = SRC_A_OLD_PC;
                w_ctrl.alu_src_b = SRC_B_IMM;
                w_ctrl.alu_op    = ALU_ADD;
                case (w_class)
                    CLS_R:               w_state_next = S_EXEC_R;
                    CLS_I:               w_state_next = S_EXEC_I;
                    CLS_LOAD, CLS_STORE: w_state_next = S_MEM_ADDR;
                    CLS_BRANCH:          w_state_next = S_BRANCH;
                    default:             w_state_next = S_TRAP;
                endcase
            end

            S_EXEC_R: begin
                w_ctrl.alu_src_a = SRC_A_RS1;
                w_ctrl.alu_src_b = SRC_B_RS2;
                w_ctrl.alu_op    = ALU_FUNCT;
                w_state_next     = S_WB_ALU;
            end

            S_EXEC_I: begin
                w_ctrl.alu_src_a = SRC_A_RS1;
                w_ctrl.alu_src_b = SRC_B_IMM;
                w_ctrl.alu_op    = ALU_FUNCT;
                w_state_next     = S_WB_ALU;
            end

            S_MEM_ADDR: begin
                w_ctrl.alu_src_a = SRC_A_RS1;
                w_ctrl.alu_src_b = SRC_B_IMM;
                w_ctrl.alu_op    = ALU_ADD;
                if (w_class == CLS_LOAD) begin
                    w_state_next = S_MEM_RD;
                end else begin
                    w_state_next = S_MEM_WR;
                end
            end

            S_MEM_RD: begin
                w_ctrl.mem_req = 1'b1;
                w_ctrl.mem_we  = 1'b0;
                w_ctrl.iord    = 1'b1;
                if (mem_ready) begin
                    w_state_next = S_WB_MEM;
                end
            end

            S_MEM_WR: begin
                w_ctrl.mem_req = 1'b1;
                w_ctrl.mem_we  = 1'b1;
                w_ctrl.iord    = 1'b1;
                if (mem_ready) begin
                    w_ctrl.instr_done = 1'b1;
                    w_state_next      = S_FETCH;
                end
            end

            S_WB_ALU: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.wb_sel     = 1'b0;
                w_ctrl.instr_done = 1'b1;
                w_state_next      = S_FETCH;
            end

            S_WB_MEM: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.wb_sel     = 1'b1;
                w_ctrl.instr_done = 1'b1;
                w_state_next      = S_FETCH;
            end

            S_BRANCH: begin
                w_ctrl.alu_src_a     = SRC_A_RS1;
                w_ctrl.alu_src_b     = SRC_B_RS2;
                w_ctrl.alu_op        = ALU_SUB;
                w_ctrl.pc_write_cond = 1'b1;
                w_ctrl.pc_src        = 1'b1;
                w_ctrl.instr_done    = 1'b1;
                w_state_next         = S_FETCH;
            end

            S_TRAP: begin
                w_ctrl.trap  = 1'b1;
                w_state_next = S_TRAP;
            end

            default: begin
                w_state_next = S_FETCH;
            end
        endcase

        // Reset silences every output in the same cycle, so an abandoned
        // memory request or half-finished instruction causes no writes.
        if (reset) begin
            w_ctrl = ctrl_idle();
        end
    end

    assign mem_req       = w_ctrl.mem_req;
    assign mem_we        = w_ctrl.mem_we;
    assign iord          = w_ctrl.iord;
    assign ir_write      = w_ctrl.ir_write;
    assign pc_write      = w_ctrl.pc_write;
    assign pc_write_cond = w_ctrl.pc_write_cond;
    assign pc_src        = w_ctrl.pc_src;
    assign alu_src_a     = w_ctrl.alu_src_a;
    assign alu_src_b     = w_ctrl.alu_src_b;
    assign alu_op        = w_ctrl.alu_op;
    assign reg_write     = w_ctrl.reg_write;
    assign wb_sel        = w_ctrl.wb_sel;
    assign instr_done    = w_ctrl.instr_done;
    assign trap          = w_ctrl.trap;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM for the RV32I core datapath. Takes the opcode, funct3 and funct7 fields produced by the instruction field parser from the latched instruction register. Sequences fetch, decode, execute, memory and write-back over several cycles, producing datapath enables, mux selects and a memory request/ready handshake. Sits between the instruction register/field parser and the shared PC, register file, ALU and unified memory port.

## Interface
Parameters:
- none; opcode and encoding constants come from the shared package.

Ports:
- `clk` in 1: core clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 7: instruction [6:0], from the field parser.
- `funct3` in 3: instruction [14:12].
- `funct7` in 7: instruction [31:25].
- `mem_ready` in 1: memory completes the current transfer this cycle.
- `mem_req` out 1: memory access request, held until accepted.
- `mem_we` out 1: 1 = store, 0 = read; valid while `mem_req`.
- `iord` out 1: memory address select, 0 = PC, 1 = ALU result register.
- `ir_write` out 1: latch instruction register.
- `pc_write` out 1: unconditional PC update.
- `pc_write_cond` out 1: PC update gated by datapath branch condition.
- `pc_src` out 1: 0 = ALU output (PC+4), 1 = branch target register.
- `alu_src_a` out 2: 0 = PC, 1 = rs1, 2 = old PC.
- `alu_src_b` out 2: 0 = rs2, 1 = constant 4, 2 = immediate.
- `alu_op` out 2: 0 = add, 1 = sub, 2 = decode from funct3/funct7.
- `reg_write` out 1: register file write of rd.
- `wb_sel` out 1: 0 = ALU result register, 1 = memory data register.
- `instr_done` out 1: one-cycle pulse on the final cycle of each instruction.
- `trap` out 1: illegal opcode seen; sticky until reset.

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, TRAP.
- Outputs are Moore, decoded from state only. The exceptions are `ir_write`, `pc_write` and `instr_done`, which may also depend on `mem_ready`.
- FETCH:
  - `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=0.
  - On `mem_ready`: `ir_write`=1, `pc_write`=1, go to DECODE. Otherwise stay.
- DECODE:
  - `alu_src_a`=2, `alu_src_b`=2, `alu_op`=0 (branch target precompute).
  - Next state by opcode:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 or 0100011 → MEM_ADDR
    - 1100011 → BRANCH
    - any other → TRAP
- EXEC_R: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=2; go to WB_ALU.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=2; go to WB_ALU.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=0. Go to MEM_RD if opcode=0000011, else MEM_WR.
- MEM_RD: `mem_req`=1, `mem_we`=0, `iord`=1. Go to WB_MEM on `mem_ready`, otherwise stay.
- MEM_WR: `mem_req`=1, `mem_we`=1, `iord`=1. On `mem_ready`: `instr_done`=1, go to FETCH.
- WB_ALU: `reg_write`=1, `wb_sel`=0, `instr_done`=1; go to FETCH.
- WB_MEM: `reg_write`=1, `wb_sel`=1, `instr_done`=1; go to FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=1, `pc_write_cond`=1, `pc_src`=1, `instr_done`=1; go to FETCH.
  - funct3 is passed through to the datapath comparator; the FSM itself does not inspect it.
- TRAP: `trap`=1, all other outputs 0; stays in TRAP until `reset`.
- funct3/funct7 matter only in EXEC_R/EXEC_I, through the datapath ALU decoder. The controller does not reject unsupported funct encodings.

## Timing
- While `reset`=1, every output is 0, including `mem_req` and `trap`.
- First cycle after `reset` falls: state is FETCH and `mem_req`=1.
- `reset` asserted mid-instruction, including during a pending `mem_req`: the next cycle is FETCH and no writes occur. The memory must tolerate an abandoned request.
- Handshake: the transfer completes in the cycle where `mem_req`&`mem_ready`=1, and the state advances on that edge.
  - `mem_ready` is ignored when `mem_req`=0.
  - `mem_req` never drops before acceptance.
  - Each wait cycle adds exactly 1 cycle of latency.
- Zero-wait latency in cycles: R/I = 4, load = 5, store = 4, branch = 3.
- `instr_done` is exactly one cycle per retired instruction. It never fires in TRAP.

## Structure
- Shared package `core_pkg` holds:
  - opcode localparams: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH
  - state enum
  - `alu_op`, `alu_src_a`, `alu_src_b` encodings
- One sub-module: `opcode_class`, a combinational opcode → class decoder (R, I, LOAD, STORE, BRANCH, ILLEGAL) used by DECODE and MEM_ADDR.
- Top: state register plus a next-state/output case statement.

## Test plan
- Reset, then `mem_ready`=1 constantly; opcode 0110011 (add x3,x1,x2).
  - States: FETCH, DECODE, EXEC_R, WB_ALU.
  - `reg_write` in cycle 4 only; `instr_done` pulses in cycle 4; next cycle is FETCH.
- Load 0000011 with `mem_ready` low for 3 cycles in MEM_RD.
  - `mem_req`=1 and `iord`=1 held for 4 cycles.
  - WB_MEM follows with `wb_sel`=1; total 8 cycles.
- Store 0100011 with zero-wait memory.
  - `mem_we`=1 only in MEM_WR; `reg_write` never asserted; 4 cycles.
- Branch 1100011.
  - `pc_write_cond`=1, `alu_op`=1, `pc_src`=1 in cycle 3; `pc_write`=1 only in the FETCH cycle.
- Opcode 1111111.
  - TRAP after DECODE; `trap`=1 persists for 20 cycles regardless of `mem_ready`.
  - `reset` pulse returns to FETCH with `trap`=0.
- `reset` asserted in MEM_RD while `mem_ready`=0.
  - Next cycle: FETCH, `mem_req`=1, `iord`=0, no `reg_write`.
